// File: rtl/lcd_rx_monitor.sv
// DE-only LCD receive monitor: recovers line/frame boundaries from DE gaps and checks frame geometry.
// Optional per-frame pixel checksum is built when LCD_RX_CHECKSUM_EN is defined.
module lcd_rx_monitor #(
  parameter int HORIZONTAL_DATA_WIDTH = 800,
  parameter int VERTICAL_DATA_WIDTH   = 480,
  parameter int VBLANK_GAP_MIN        = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_data_en,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_px_valid,
  output logic [23:0] o_px_data,
  output logic [11:0] o_px_x,
  output logic [10:0] o_px_y,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic        o_err_width,
  output logic        o_err_height,
  output logic [11:0] o_line_width,
  output logic [10:0] o_line_count,
  output logic [31:0] o_frame_sum
);

  localparam logic [15:0] GAP_MIN = 16'(VBLANK_GAP_MIN);
  localparam logic [11:0] H_W     = 12'(HORIZONTAL_DATA_WIDTH);
  localparam logic [10:0] V_W     = 11'(VERTICAL_DATA_WIDTH);

  typedef enum logic [1:0] {SEARCH, VBLANK, ACTIVE, HGAP} state_t;

  state_t      state_reg;
  logic        de_s1_reg;
  logic [23:0] rgb_s1_reg;
  logic [15:0] gap_reg, gap_next;
  logic [11:0] x_reg, x_inc, width_reg;
  logic [10:0] y_reg, y_inc, lines_reg, lines_inc;
  logic        err_w_reg;
  logic        done_hit;

  // The gap counter follows live DE, so it counts the low samples up to and including this edge.
  always_comb begin
    gap_next  = i_data_en ? 16'd0 : ((gap_reg == 16'hFFFF) ? gap_reg : gap_reg + 16'd1);
    x_inc     = (x_reg == 12'hFFF) ? x_reg : x_reg + 12'd1;
    y_inc     = (y_reg == 11'h7FF) ? y_reg : y_reg + 11'd1;
    lines_inc = (lines_reg == 11'h7FF) ? lines_reg : lines_reg + 11'd1;
    done_hit  = (state_reg == HGAP) && (gap_next >= GAP_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SEARCH;
      de_s1_reg    <= 1'b0;
      rgb_s1_reg   <= '0;
      gap_reg      <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      lines_reg    <= '0;
      width_reg    <= '0;
      err_w_reg    <= 1'b0;
      o_px_valid   <= 1'b0;
      o_px_data    <= '0;
      o_px_x       <= '0;
      o_px_y       <= '0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_err_width  <= 1'b0;
      o_err_height <= 1'b0;
      o_line_width <= '0;
      o_line_count <= '0;
    end else begin
      de_s1_reg    <= i_data_en;
      rgb_s1_reg   <= {i_red, i_green, i_blue};
      gap_reg      <= gap_next;
      o_px_valid   <= 1'b0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
      case (state_reg)
        SEARCH: begin
          if (gap_next >= GAP_MIN) state_reg <= VBLANK;
        end
        VBLANK: begin
          if (de_s1_reg) begin
            state_reg  <= ACTIVE;
            o_px_valid <= 1'b1;
            o_px_data  <= rgb_s1_reg;
            o_px_x     <= '0;
            o_px_y     <= '0;
            o_sof      <= 1'b1;
            o_eol      <= !i_data_en;
            x_reg      <= 12'd1;
            y_reg      <= '0;
            lines_reg  <= '0;
            err_w_reg  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (de_s1_reg) begin
            o_px_valid <= 1'b1;
            o_px_data  <= rgb_s1_reg;
            o_px_x     <= x_reg;
            o_px_y     <= y_reg;
            o_eol      <= !i_data_en;
            x_reg      <= x_inc;
          end else begin
            state_reg <= HGAP;
            width_reg <= x_reg;
            lines_reg <= lines_inc;
            if (x_reg != H_W) err_w_reg <= 1'b1;
          end
        end
        HGAP: begin
          if (done_hit) begin
            state_reg    <= VBLANK;
            o_frame_done <= 1'b1;
            o_line_width <= width_reg;
            o_line_count <= lines_reg;
            o_err_width  <= err_w_reg;
            o_err_height <= (lines_reg != V_W);
            o_frame_ok   <= !err_w_reg && (lines_reg == V_W);
          end else if (de_s1_reg) begin
            state_reg  <= ACTIVE;
            o_px_valid <= 1'b1;
            o_px_data  <= rgb_s1_reg;
            o_px_x     <= '0;
            o_px_y     <= y_inc;
            o_eol      <= !i_data_en;
            x_reg      <= 12'd1;
            y_reg      <= y_inc;
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

`ifdef LCD_RX_CHECKSUM_EN
  logic [31:0] sum_reg, frame_sum_reg;
  logic        pix_fire, sof_fire;

  assign pix_fire    = de_s1_reg && (state_reg != SEARCH);
  assign sof_fire    = de_s1_reg && (state_reg == VBLANK);
  assign o_frame_sum = frame_sum_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg       <= '0;
      frame_sum_reg <= '0;
    end else begin
      if (sof_fire)      sum_reg <= {8'h00, rgb_s1_reg};
      else if (pix_fire) sum_reg <= sum_reg + {8'h00, rgb_s1_reg};
      if (done_hit) frame_sum_reg <= sum_reg;
    end
  end
`else
  assign o_frame_sum = 32'd0;
`endif

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Randomized bench for lcd_rx_monitor: a frame-level model predicts pixels and per-frame status,
// and each scenario task compares what the monitor captured against that prediction.
module tb_lcd_rx_monitor;
  localparam int H = 16;
  localparam int V = 8;
  localparam int G = 40;
  localparam int HB = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        de = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        o_px_valid, o_sof, o_eol, o_frame_done, o_frame_ok, o_err_width, o_err_height;
  logic [23:0] o_px_data;
  logic [11:0] o_px_x, o_line_width;
  logic [10:0] o_px_y, o_line_count;
  logic [31:0] o_frame_sum;
  logic [108:0] all_out;

  lcd_rx_monitor #(.HORIZONTAL_DATA_WIDTH(H), .VERTICAL_DATA_WIDTH(V), .VBLANK_GAP_MIN(G)) dut (
    .clk(clk), .reset(reset), .i_data_en(de), .i_red(r), .i_green(g), .i_blue(b),
    .o_px_valid(o_px_valid), .o_px_data(o_px_data), .o_px_x(o_px_x), .o_px_y(o_px_y),
    .o_sof(o_sof), .o_eol(o_eol), .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
    .o_err_width(o_err_width), .o_err_height(o_err_height), .o_line_width(o_line_width),
    .o_line_count(o_line_count), .o_frame_sum(o_frame_sum)
  );

  assign all_out = {o_px_valid, o_px_data, o_px_x, o_px_y, o_sof, o_eol, o_frame_done, o_frame_ok,
                    o_err_width, o_err_height, o_line_width, o_line_count, o_frame_sum};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0] d; logic [11:0] x; logic [10:0] y; logic sof; logic eol;
  } px_t;
  typedef struct packed {
    logic [31:0] t; logic [11:0] w; logic [10:0] n; logic ew; logic eh; logic ok; logic [31:0] sum;
  } st_t;

  px_t exp_px[$], obs_px[$];
  st_t exp_st[$], obs_st[$];
  int  checks = 0, failures = 0, stray = 0;

  // Frame-level reference state
  bit          armed = 0, f_open = 0, f_errw = 0;
  int          f_lines = 0, f_last_w = 0, last_high = 0;
  logic [31:0] f_sum = '0;

  always @(negedge clk) begin
    if (o_px_valid) obs_px.push_back({o_px_data, o_px_x, o_px_y, o_sof, o_eol});
    else if (o_sof || o_eol) stray++;
    if (o_frame_done)
      obs_st.push_back({32'(cyc), o_line_width, o_line_count, o_err_width, o_err_height, o_frame_ok, o_frame_sum});
  end

  task automatic clear_q();
    exp_px.delete(); obs_px.delete(); exp_st.delete(); obs_st.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(negedge clk); de = 1'b0; end
  endtask

  task automatic drive_line(input int w, input bit blue);
    px_t e;
    for (int p = 0; p < w; p++) begin
      @(negedge clk);
      de = 1'b1;
      if (blue) {r, g, b} = 24'h0000FF;
      else      {r, g, b} = 24'($urandom);
      last_high = cyc + 1;
      if (armed) begin
        if (!f_open) begin f_open = 1; f_lines = 0; f_errw = 0; f_sum = '0; end
        e.d = {r, g, b};
        e.x = 12'((p > 4095) ? 4095 : p);
        e.y = 11'(f_lines);
        e.sof = (f_lines == 0) && (p == 0);
        e.eol = (p == w - 1);
        exp_px.push_back(e);
        f_sum = f_sum + {8'h00, r, g, b};
      end
    end
    if (armed) begin
      f_last_w = (w > 4095) ? 4095 : w;
      if (f_last_w != H) f_errw = 1;
      if (f_lines < 2047) f_lines++;
    end
  endtask

  task automatic drive_gap(input int n);
    st_t s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      de = 1'b0;
      {r, g, b} = 24'($urandom);
    end
    if (n >= G) begin
      if (armed && f_open) begin
        s.t = 32'(last_high + G);
        s.w = 12'(f_last_w);
        s.n = 11'(f_lines);
        s.ew = f_errw;
        s.eh = (f_lines != V);
        s.ok = !f_errw && (f_lines == V);
`ifdef LCD_RX_CHECKSUM_EN
        s.sum = f_sum;
`else
        s.sum = 32'd0;
`endif
        exp_st.push_back(s);
      end
      armed = 1;
      f_open = 0;
    end
  endtask

  task automatic drive_frame(input int lines, input int w, input int vgap, input bit blue);
    for (int l = 0; l < lines; l++) begin
      drive_line(w, blue);
      if (l < lines - 1) drive_gap(HB);
    end
    drive_gap(vgap);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    checks++;
    if (o_frame_ok !== 1'b0) begin failures++; $display("FAIL reset_frame_ok got=%b want=0", o_frame_ok); end
    reset = 1'b0;
    armed = 0; f_open = 0;
    $display("reset: outputs sampled under reset");
  endtask

  task automatic test_geometry();
    clear_q();
    drive_frame(V, H, G + 10, 0);
    drive_frame(V, H, G + 10, 0);
    drive_frame(V, H, G + 10, 0);
    settle(4);
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL geom_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      checks++;
      if (obs_px[i] !== exp_px[i]) begin failures++; $display("FAIL geom_px[%0d] got=%h want=%h", i, obs_px[i], exp_px[i]); end
    end
    checks++;
    if (obs_st.size() != 2) begin failures++; $display("FAIL geom_done_count got=%0d want=2", obs_st.size()); end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      checks++;
      if (obs_st[i] !== exp_st[i]) begin failures++; $display("FAIL geom_status[%0d] got=%h want=%h", i, obs_st[i], exp_st[i]); end
    end
    checks++;
    if ({o_frame_ok, o_line_width, o_line_count} !== {1'b1, 12'(H), 11'(V)})
      begin failures++; $display("FAIL geom_final got=%b/%0d/%0d want=1/%0d/%0d", o_frame_ok, o_line_width, o_line_count, H, V); end
    if (obs_px.size() > 0) begin
      checks++;
      if ({obs_px[0].sof, obs_px[0].x, obs_px[0].y} !== {1'b1, 12'd0, 11'd0})
        begin failures++; $display("FAIL geom_first_px got=%b/%0d/%0d want=1/0/0", obs_px[0].sof, obs_px[0].x, obs_px[0].y); end
    end
    $display("geometry: pixels=%0d frames=%0d", obs_px.size(), obs_st.size());
  endtask

  task automatic test_checksum();
    logic [31:0] want;
`ifdef LCD_RX_CHECKSUM_EN
    want = 32'(H * V * 255);
`else
    want = 32'd0;
`endif
    clear_q();
    drive_frame(V, H, G + 5, 1);
    settle(4);
    checks++;
    if (o_frame_sum !== want) begin failures++; $display("FAIL checksum got=%h want=%h", o_frame_sum, want); end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      checks++;
      if (obs_st[i] !== exp_st[i]) begin failures++; $display("FAIL checksum_status got=%h want=%h", obs_st[i], exp_st[i]); end
    end
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL checksum_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    $display("checksum: frame_sum=%h", o_frame_sum);
  endtask

  task automatic test_bad_width();
    clear_q();
    for (int l = 0; l < V; l++) begin
      drive_line((l == 3) ? H - 1 : H, 0);
      drive_gap((l == V - 1) ? G + 5 : HB);
    end
    settle(4);
    checks++;
    if ({o_err_width, o_err_height, o_frame_ok} !== 3'b100)
      begin failures++; $display("FAIL badw_flags got=%b%b%b want=100", o_err_width, o_err_height, o_frame_ok); end
    drive_frame(V, H, G + 5, 0);
    settle(4);
    checks++;
    if ({o_err_width, o_err_height, o_frame_ok} !== 3'b001)
      begin failures++; $display("FAIL badw_recover got=%b%b%b want=001", o_err_width, o_err_height, o_frame_ok); end
    checks++;
    if (obs_st.size() != exp_st.size()) begin failures++; $display("FAIL badw_done_count got=%0d want=%0d", obs_st.size(), exp_st.size()); end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      checks++;
      if (obs_st[i] !== exp_st[i]) begin failures++; $display("FAIL badw_status[%0d] got=%h want=%h", i, obs_st[i], exp_st[i]); end
    end
    $display("bad_width: frames=%0d", obs_st.size());
  endtask

  task automatic test_gap_threshold();
    int lh;
    clear_q();
    drive_line(H, 0); drive_gap(HB);
    drive_line(H, 0); drive_gap(HB);
    drive_line(H, 0); drive_gap(G - 1);
    drive_line(H, 0); drive_gap(HB);
    drive_line(H, 0);
    lh = last_high;
    drive_gap(G);
    drive_frame(V, H, G + 5, 0);
    settle(4);
    checks++;
    if (obs_st.size() != 2) begin failures++; $display("FAIL gap_done_count got=%0d want=2", obs_st.size()); end
    if (obs_st.size() > 0) begin
      checks++;
      if (obs_st[0].t !== 32'(lh + G)) begin failures++; $display("FAIL gap_done_time got=%0d want=%0d", obs_st[0].t, lh + G); end
      checks++;
      if ({obs_st[0].n, obs_st[0].eh, obs_st[0].ok} !== {11'd5, 1'b1, 1'b0})
        begin failures++; $display("FAIL gap_status got=%0d/%b/%b want=5/1/0", obs_st[0].n, obs_st[0].eh, obs_st[0].ok); end
    end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      checks++;
      if (obs_st[i] !== exp_st[i]) begin failures++; $display("FAIL gap_status[%0d] got=%h want=%h", i, obs_st[i], exp_st[i]); end
    end
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL gap_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      checks++;
      if (obs_px[i] !== exp_px[i]) begin failures++; $display("FAIL gap_px[%0d] got=%h want=%h", i, obs_px[i], exp_px[i]); end
    end
    $display("gap_threshold: frames=%0d", obs_st.size());
  endtask

  task automatic test_single_pixel();
    clear_q();
    drive_line(1, 0); drive_gap(HB);
    for (int l = 1; l < V; l++) begin
      drive_line(H, 0);
      drive_gap((l == V - 1) ? G + 3 : HB);
    end
    settle(4);
    if (obs_px.size() > 0) begin
      checks++;
      if ({obs_px[0].sof, obs_px[0].eol} !== 2'b11) begin failures++; $display("FAIL single_sof_eol got=%b%b want=11", obs_px[0].sof, obs_px[0].eol); end
    end
    checks++;
    if (o_err_width !== 1'b1) begin failures++; $display("FAIL single_errw got=%b want=1", o_err_width); end
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL single_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      checks++;
      if (obs_px[i] !== exp_px[i]) begin failures++; $display("FAIL single_px[%0d] got=%h want=%h", i, obs_px[i], exp_px[i]); end
    end
    $display("single_pixel: pixels=%0d", obs_px.size());
  endtask

  task automatic test_saturation();
    clear_q();
    drive_line(4100, 0);
    drive_gap(G + 2);
    for (int l = 0; l < 2050; l++) begin
      drive_line(1, 0);
      drive_gap((l == 2049) ? G + 2 : 2);
    end
    settle(4);
    checks++;
    if (obs_st.size() != 2) begin failures++; $display("FAIL sat_done_count got=%0d want=2", obs_st.size()); end
    if (obs_st.size() == 2) begin
      checks++;
      if (obs_st[0].w !== 12'd4095) begin failures++; $display("FAIL sat_width got=%0d want=4095", obs_st[0].w); end
      checks++;
      if (obs_st[1].n !== 11'd2047) begin failures++; $display("FAIL sat_lines got=%0d want=2047", obs_st[1].n); end
    end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      checks++;
      if (obs_st[i] !== exp_st[i]) begin failures++; $display("FAIL sat_status[%0d] got=%h want=%h", i, obs_st[i], exp_st[i]); end
    end
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL sat_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      checks++;
      if (obs_px[i] !== exp_px[i]) begin failures++; $display("FAIL sat_px[%0d] got=%h want=%h", i, obs_px[i], exp_px[i]); end
    end
    $display("saturation: pixels=%0d frames=%0d", obs_px.size(), obs_st.size());
  endtask

  task automatic test_random();
    int lines, w;
    clear_q();
    for (int f = 0; f < 4; f++) begin
      lines = V - 1 + int'($urandom_range(0, 2));
      for (int l = 0; l < lines; l++) begin
        w = ($urandom_range(0, 3) == 0) ? H - 1 + int'($urandom_range(0, 2)) : H;
        drive_line(w, 0);
        drive_gap((l == lines - 1) ? int'($urandom_range(G, G + 20)) : int'($urandom_range(1, G - 1)));
      end
      $display("random: frame %0d lines=%0d", f, lines);
    end
    settle(4);
    checks++;
    if (obs_st.size() != exp_st.size()) begin failures++; $display("FAIL rand_done_count got=%0d want=%0d", obs_st.size(), exp_st.size()); end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      checks++;
      if (obs_st[i] !== exp_st[i]) begin failures++; $display("FAIL rand_status[%0d] got=%h want=%h", i, obs_st[i], exp_st[i]); end
    end
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL rand_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      checks++;
      if (obs_px[i] !== exp_px[i]) begin failures++; $display("FAIL rand_px[%0d] got=%h want=%h", i, obs_px[i], exp_px[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int l = 0; l < 4; l++) begin drive_line(H, 0); drive_gap(3); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL midreset_outputs got=%h want=0", all_out); end
    reset = 1'b0;
    armed = 0; f_open = 0;
    exp_px.delete();
    for (int l = 4; l < V; l++) begin drive_line(H, 0); drive_gap((l == V - 1) ? G + 10 : HB); end
    checks++;
    if (obs_px.size() != 4 * H) begin failures++; $display("FAIL midreset_px_before got=%0d want=%0d", obs_px.size(), 4 * H); end
    obs_px.delete();
    drive_frame(V, H, G + 5, 0);
    settle(4);
    checks++;
    if (obs_st.size() != 1) begin failures++; $display("FAIL midreset_done_count got=%0d want=1", obs_st.size()); end
    checks++;
    if ({o_line_count, o_frame_ok} !== {11'(V), 1'b1})
      begin failures++; $display("FAIL midreset_status got=%0d/%b want=%0d/1", o_line_count, o_frame_ok, V); end
    checks++;
    if (obs_px.size() != exp_px.size()) begin failures++; $display("FAIL midreset_px_count got=%0d want=%0d", obs_px.size(), exp_px.size()); end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      checks++;
      if (obs_px[i] !== exp_px[i]) begin failures++; $display("FAIL midreset_px[%0d] got=%h want=%h", i, obs_px[i], exp_px[i]); end
    end
    $display("reset_mid: pixels after resync=%0d", obs_px.size());
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_checksum();
    test_bad_width();
    test_gap_threshold();
    test_single_pixel();
    test_saturation();
    test_random();
    test_reset_mid();
    checks++;
    if (stray != 0) begin failures++; $display("FAIL unqualified_sof_eol got=%0d want=0", stray); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
